load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 129 ++++++++++++
 tb/tb_load_store_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit bridging a CPU request/response handshake to a single-port RAM.
// Define LSU_MISALIGN_TRAP_EN to turn misaligned halfword/word accesses into errors.
module load_store_unit #(
    parameter int MEM_WORDS = 131072
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        ram_wren,
    output logic [29:0] ram_address,
    output logic [31:0] ram_data,
    output logic [3:0]  ram_byteena,
    input  logic [31:0] ram_q
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam logic [31:0] MEM_LIMIT = 32'(MEM_WORDS);

    logic [1:0]  state;
    logic [1:0]  lane;
    logic [1:0]  lane_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        accept;
    logic        size_err;
    logic        range_err;
    logic        misalign;
    logic        err;
    logic [31:0] shifted;
    logic [31:0] load_val;

    assign req_ready = (state == IDLE) & ~reset;
    assign accept    = req_valid & req_ready;
    assign size_err  = (req_size == 2'b11);
    assign range_err = ({2'b00, req_addr[31:2]} >= MEM_LIMIT);

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = ((req_size == 2'b01) & req_addr[0])
                    | ((req_size == 2'b10) & (|req_addr[1:0]));
`else
    assign misalign = 1'b0;
`endif

    assign err         = size_err | range_err | misalign;
    assign ram_wren    = accept & req_we & ~err;
    assign ram_address = req_addr[31:2];

    always_comb begin
        lane        = 2'b00;
        ram_byteena = 4'b0000;
        ram_data    = req_wdata;
        case (req_size)
            2'b00: begin
                lane        = req_addr[1:0];
                ram_byteena = 4'b0001 << lane;
                ram_data    = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                lane        = {req_addr[1], 1'b0};
                ram_byteena = 4'b0011 << lane;
                ram_data    = {2{req_wdata[15:0]}};
            end
            2'b10: ram_byteena = 4'b1111;
            default: ram_byteena = 4'b0000;
        endcase
    end

    // RAM read data arrives one cycle after accept; pick the lane and extend.
    assign shifted = ram_q >> {lane_q, 3'b000};

    always_comb begin
        case (size_q)
            2'b00:   load_val = {{24{signed_q & shifted[7]}}, shifted[7:0]};
            2'b01:   load_val = {{16{signed_q & shifted[15]}}, shifted[15:0]};
            default: load_val = shifted;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            lane_q   <= '0;
            size_q   <= '0;
            signed_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        lane_q   <= lane;
                        size_q   <= req_size;
                        signed_q <= req_signed;
                        rdata_q  <= '0;
                        err_q    <= err;
                        state    <= (err | req_we) ? RESP : LOAD;
                    end
                end
                LOAD: begin
                    rdata_q <= load_val;
                    state   <= RESP;
                end
                RESP: begin
                    if (resp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign resp_valid = (state == RESP) & ~reset;
    assign resp_err   = err_q & resp_valid;
    assign resp_rdata = resp_valid ? rdata_q : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus random traffic
// checked against a byte-array memory model.
module tb_load_store_unit;

    localparam int MEMW = 1024;
    localparam int MEMB = MEMW * 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        ram_wren;
    logic [29:0] ram_address;
    logic [31:0] ram_data;
    logic [3:0]  ram_byteena;
    logic [31:0] ram_q;

    logic [31:0] ram [0:MEMW-1];
    logic [7:0]  ref_mem [0:MEMB-1];

    int passed = 0;
    int total = 0;

    load_store_unit #(.MEM_WORDS(MEMW)) dut (
        .clock(clock),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we(req_we),
        .req_size(req_size),
        .req_signed(req_signed),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_rdata(resp_rdata),
        .resp_err(resp_err),
        .ram_wren(ram_wren),
        .ram_address(ram_address),
        .ram_data(ram_data),
        .ram_byteena(ram_byteena),
        .ram_q(ram_q)
    );

    always #5 clock = ~clock;

    // Word-wide RAM with byte enables and a one-cycle registered read.
    always @(posedge clock) begin
        if (ram_wren) begin
            for (int i = 0; i < 4; i++)
                if (ram_byteena[i])
                    ram[ram_address[9:0]][8*i +: 8] <= ram_data[8*i +: 8];
        end
        ram_q <= ram[ram_address[9:0]];
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    endtask

    task automatic do_req(input logic we, input logic [1:0] size,
                          input logic sgn, input logic [31:0] addr,
                          input logic [31:0] wdata, input int hold);
        int nbytes;
        int off;
        int base;
        bit bad;
        bit mis;
        logic [31:0] exp_rdata;
        logic [31:0] exp_data;
        logic [3:0]  exp_be;
        int lat;
        int n;

        nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        off = (size == 2'd0) ? int'(addr % 4) :
              (size == 2'd1) ? int'(addr % 4) / 2 * 2 : 0;
        mis = (size == 2'd1 && addr % 2 != 0) ||
              (size == 2'd2 && addr % 4 != 0);
        bad = (size == 2'd3) || ((addr / 4) >= MEMW);
`ifdef LSU_MISALIGN_TRAP_EN
        if (mis) bad = 1;
`endif
        base = int'((addr / 4) * 4) + off;
        exp_be = 4'(((1 << nbytes) - 1) << off);
        exp_data = (size == 2'd0) ? {4{wdata[7:0]}} :
                   (size == 2'd1) ? {2{wdata[15:0]}} : wdata;
        exp_rdata = 0;
        if (!bad && !we) begin
            for (int i = 0; i < nbytes; i++)
                exp_rdata = exp_rdata | (32'(ref_mem[base + i]) << (8 * i));
            if (sgn && nbytes < 4 && exp_rdata[8*nbytes-1])
                exp_rdata = exp_rdata | ~((32'd1 << (8 * nbytes)) - 1);
        end
        if (!bad && we)
            for (int i = 0; i < nbytes; i++)
                ref_mem[base + i] = wdata[8*i +: 8];

        @(negedge clock);
        req_valid = 1;
        req_we = we;
        req_size = size;
        req_signed = sgn;
        req_addr = addr;
        req_wdata = wdata;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        #1;
        check("req_ready_idle", 32'(req_ready), 1);
        check("ram_wren_accept", 32'(ram_wren), 32'(we & !bad));
        check("ram_address", 32'(ram_address), addr >> 2);
        if (we && !bad) begin
            check("ram_byteena", 32'(ram_byteena), 32'(exp_be));
            check("ram_data", ram_data, exp_data);
        end
        @(posedge clock);
        #1;
        req_valid = 0;
        req_we = 0;
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
        end while (!resp_valid && lat < 8);
        check("latency", lat, (we || bad) ? 1 : 2);
        check("resp_err", 32'(resp_err), 32'(bad));
        check("resp_rdata", resp_rdata, exp_rdata);
        check("ram_wren_idle", 32'(ram_wren), 0);
        check("req_ready_busy", 32'(req_ready), 0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clock);
            check("hold_valid", 32'(resp_valid), 1);
            check("hold_rdata", resp_rdata, exp_rdata);
            check("hold_ready", 32'(req_ready), 0);
        end
        resp_ready = 1;
        @(posedge clock);
        #1;
        resp_ready = 0;
        @(negedge clock);
        check("back_idle_valid", 32'(resp_valid), 0);
        check("back_idle_ready", 32'(req_ready), 1);
    endtask

    initial begin
        for (int i = 0; i < MEMW; i++) ram[i] = 0;
        for (int i = 0; i < MEMB; i++) ref_mem[i] = 0;
        reset = 1;
        req_valid = 1;
        req_we = 1;
        req_size = 2'd2;
        req_signed = 0;
        req_addr = 32'h20;
        req_wdata = 32'h12345678;
        resp_ready = 0;
        repeat (2) @(negedge clock);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_resp_valid", 32'(resp_valid), 0);
        check("rst_resp_err", 32'(resp_err), 0);
        check("rst_resp_rdata", resp_rdata, 0);
        check("rst_ram_wren", 32'(ram_wren), 0);
        req_valid = 0;
        req_we = 0;
        reset = 0;
        @(negedge clock);
        check("post_rst_ready", 32'(req_ready), 1);

        do_req(1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 0);
        do_req(0, 2'd2, 0, 32'h10, 0, 0);
        do_req(1, 2'd0, 0, 32'h13, 32'h00000080, 0);
        do_req(0, 2'd0, 1, 32'h13, 0, 0);
        do_req(0, 2'd0, 0, 32'h13, 0, 0);
        do_req(0, 2'd1, 1, 32'h11, 0, 0);
        do_req(1, 2'd1, 0, 32'h11, 32'h0000ABCD, 0);
        do_req(0, 2'd2, 0, MEMW * 4, 0, 0);
        do_req(1, 2'd2, 0, 32'hFFFFFFFC, 32'h1, 0);
        do_req(0, 2'd3, 0, 32'h10, 0, 0);
        do_req(1, 2'd3, 0, 32'h10, 32'h5, 0);
        do_req(0, 2'd2, 0, 32'h10, 0, 5);
        do_req(0, 2'd1, 1, 32'h12, 0, 5);

        // Reset while a load is in flight.
        @(negedge clock);
        req_valid = 1;
        req_we = 0;
        req_size = 2'd2;
        req_addr = 32'h10;
        @(posedge clock);
        #1;
        req_valid = 0;
        @(negedge clock);
        reset = 1;
        @(negedge clock);
        check("rstload_valid", 32'(resp_valid), 0);
        check("rstload_ready", 32'(req_ready), 0);
        reset = 0;
        @(negedge clock);
        check("rstload_ready_after", 32'(req_ready), 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("no_stale_resp", 32'(resp_valid), 0);
        end

        for (int t = 0; t < 80; t++) begin
            logic [1:0] sz;
            logic [31:0] a;
            sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            if ($urandom_range(0, 9) == 0)
                a = MEMW * 4 + $urandom_range(0, 4095);
            else
                a = $urandom_range(0, 127);
            do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a,
                   $urandom, $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
